// File: rtl/lc3_intc.sv
// Multi-source prioritised interrupt controller for the LC-3 core.
// Memory-mapped IMR/IPR/PRI registers, one arbitrated request to control.
module lc3_intc #(
    parameter int          NUM_SRC     = 8,
    parameter int          SYNC_STAGES = 2,
    parameter int          EDGE_MODE   = 1,
    parameter logic [7:0]  BASE_VEC    = 8'h80
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [2:0]         cpu_pri,
    input  logic               io_sel,
    input  logic [3:0]         io_addr,
    input  logic               io_we,
    input  logic [15:0]        io_wdata,
    output logic [15:0]        io_rdata,
    output logic               int_req,
    input  logic               int_ack,
    output logic [7:0]         int_vec,
    output logic [2:0]         int_pri
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] sync_out;
    logic [NUM_SRC-1:0] imr;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] elig;
    logic [2:0]         pri_q [NUM_SRC];
    logic [2:0]         win;
    logic [2:0]         win_q;
    logic [2:0]         best;
    logic               any;
    logic               load;
    logic               wr;
    logic               unused;

    assign wr       = io_sel & io_we;
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign unused   = ^io_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imr <= '0;
            for (int k = 0; k < NUM_SRC; k++) pri_q[k] <= '0;
        end else if (wr) begin
            if (io_addr == 4'h0) imr <= io_wdata[NUM_SRC-1:0];
            for (int k = 0; k < NUM_SRC; k++)
                if (io_addr == 4'(8 + k)) pri_q[k] <= io_wdata[2:0];
        end
    end

    generate
        if (EDGE_MODE != 0) begin : g_edge
            logic [NUM_SRC-1:0] prev_q;
            logic [NUM_SRC-1:0] pend_q;
            logic [NUM_SRC-1:0] rise;
            logic [NUM_SRC-1:0] clr;

            assign rise = sync_out & ~prev_q;

            // set is OR-ed in after the clear so a same-cycle set wins
            always_comb begin
                clr = '0;
                if (wr && io_addr == 4'h1) clr = io_wdata[NUM_SRC-1:0];
                if (state == S_REQ && int_ack)
                    clr = clr | (NUM_SRC'(1) << win_q);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prev_q <= '0;
                    pend_q <= '0;
                end else begin
                    prev_q <= sync_out;
                    pend_q <= (pend_q & ~clr) | rise;
                end
            end

            assign pend = pend_q;
        end else begin : g_level
            assign pend = sync_out;
        end
    endgenerate

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++)
            elig[k] = pend[k] & imr[k] & (pri_q[k] > cpu_pri);
    end

    // strict compare keeps the lowest index among equal priorities
    always_comb begin
        win  = '0;
        best = '0;
        any  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (elig[k] && (!any || pri_q[k] > best)) begin
                any  = 1'b1;
                best = pri_q[k];
                win  = 3'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (any) state_nxt = S_REQ;
            S_REQ:  if (int_ack || !elig[win_q]) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        int_req = (state == S_REQ);
        load    = (state == S_IDLE) && any;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q   <= '0;
            int_vec <= '0;
            int_pri <= '0;
        end else if (load) begin
            win_q   <= win;
            int_vec <= BASE_VEC + 8'(win);
            int_pri <= best;
        end
    end

    always_comb begin
        io_rdata = '0;
        if (io_sel) begin
            if (io_addr == 4'h0)
                io_rdata[NUM_SRC-1:0] = imr;
            else if (io_addr == 4'h1)
                io_rdata[NUM_SRC-1:0] = pend;
            else if (io_addr[3] && 32'(io_addr[2:0]) < NUM_SRC)
                io_rdata[2:0] = pri_q[io_addr[2:0]];
        end
    end

endmodule
